// File: rtl/dac_sched_pkg.sv
// dac_sched_pkg: shared state encoding, widths and DAC operating-mode codes.
package dac_sched_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_START, ST_WAIT} state_e;
    localparam int DAC_DATA_W = 12;
    localparam int DAC_PD_W = 2;
    localparam logic [DAC_PD_W-1:0] PD_NORMAL = 2'b00;
    localparam logic [DAC_PD_W-1:0] PD_1K = 2'b01;
    localparam logic [DAC_PD_W-1:0] PD_100K = 2'b10;
    localparam logic [DAC_PD_W-1:0] PD_HIZ = 2'b11;
endpackage

// File: rtl/dac_sched_chan.sv
// dac_sched_chan: one-deep sample holding register with valid/ready handshake.
module dac_sched_chan
    import dac_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic [DAC_DATA_W-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  clear_i,
    output logic                  pending_o,
    output logic [DAC_DATA_W-1:0] data_o
);
    logic                  pending_q, pending_d;
    logic [DAC_DATA_W-1:0] data_q, data_d;
    logic                  take;

    assign take = valid_i & ~pending_q;
    // clear only drops a sample that was already held; a fresh accept survives
    always_comb begin
        pending_d = take | (pending_q & ~clear_i);
        data_d = take ? data_i : data_q;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= 1'b0;
            data_q <= '0;
        end else begin
            pending_q <= pending_d;
            data_q <= data_d;
        end
    end

    assign ready_o = ~pending_q;
    assign pending_o = pending_q;
    assign data_o = data_q;
endmodule

// File: rtl/dac_update_scheduler.sv
// dac_update_scheduler: buffers two DAC channels and launches spaced update frames,
// optionally pairing both channels with a timeout.
module dac_update_scheduler
    import dac_sched_pkg::*;
#(
    parameter int FRAME_CYCLES = 360,
    parameter int SYNC_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  sync_mode_i,
    input  logic [DAC_DATA_W-1:0] ch0_data_i,
    input  logic                  ch0_valid_i,
    output logic                  ch0_ready_o,
    input  logic [DAC_DATA_W-1:0] ch1_data_i,
    input  logic                  ch1_valid_i,
    output logic                  ch1_ready_o,
    input  logic [DAC_PD_W-1:0]   pd0_i,
    input  logic [DAC_PD_W-1:0]   pd1_i,
    output logic                  dac_en_o,
    output logic [DAC_DATA_W-1:0] dac_data0_o,
    output logic [DAC_DATA_W-1:0] dac_data1_o,
    output logic                  dac_upd0_o,
    output logic                  dac_upd1_o,
    output logic [DAC_PD_W-1:0]   dac_pd0_o,
    output logic [DAC_PD_W-1:0]   dac_pd1_o,
    output logic                  busy_o,
    output logic [15:0]           frame_cnt_o
);
    localparam int WW = FRAME_CYCLES > 1 ? $clog2(FRAME_CYCLES) : 1;
    localparam int TW = SYNC_TIMEOUT > 1 ? $clog2(SYNC_TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LOAD = WW'(FRAME_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX = TW'(SYNC_TIMEOUT - 1);

    state_e                state_q;
    logic [WW-1:0]         wait_q;
    logic [TW-1:0]         to_q, to_d;
    logic [1:0]            pending, upd_q;
    logic [DAC_DATA_W-1:0] hold0, hold1, data0_q, data1_q;
    logic [DAC_PD_W-1:0]   pd0_q, pd1_q;
    logic                  en_q, busy_q;
    logic [15:0]           cnt_q;
    logic                  one_pending, launch;

    // a channel is cleared by its own update pulse, so only delivered samples are dropped
    dac_sched_chan u_ch0 (
        .clk(clk), .rst_i(rst_i), .data_i(ch0_data_i), .valid_i(ch0_valid_i),
        .ready_o(ch0_ready_o), .clear_i(upd_q[0]), .pending_o(pending[0]), .data_o(hold0)
    );
    dac_sched_chan u_ch1 (
        .clk(clk), .rst_i(rst_i), .data_i(ch1_data_i), .valid_i(ch1_valid_i),
        .ready_o(ch1_ready_o), .clear_i(upd_q[1]), .pending_o(pending[1]), .data_o(hold1)
    );

    assign one_pending = ^pending;
    assign launch = (state_q == ST_IDLE) & enable_i &
                    (sync_mode_i ? (&pending | (one_pending & (to_q == TO_MAX))) : |pending);

    always_comb begin
        to_d = (state_q == ST_IDLE && sync_mode_i && one_pending)
             ? ((to_q == TO_MAX) ? to_q : to_q + TW'(1)) : '0;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) to_q <= '0;
        else to_q <= to_d;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            wait_q <= '0;
            upd_q <= '0;
            data0_q <= '0;
            data1_q <= '0;
            pd0_q <= '0;
            pd1_q <= '0;
            en_q <= 1'b0;
            busy_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            upd_q <= '0;
            en_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (launch) begin
                    state_q <= ST_LOAD;
                    busy_q <= 1'b1;
                    upd_q <= pending;
                    if (pending[0]) data0_q <= hold0;
                    if (pending[1]) data1_q <= hold1;
                    pd0_q <= pd0_i;
                    pd1_q <= pd1_i;
                end
                ST_LOAD: begin
                    state_q <= ST_START;
                    en_q <= 1'b1;
                    cnt_q <= cnt_q + 16'd1;
                    wait_q <= WAIT_LOAD;
                end
                ST_START: state_q <= ST_WAIT;
                default: begin
                    if (wait_q == '0) begin
                        state_q <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        wait_q <= wait_q - WW'(1);
                    end
                end
            endcase
        end
    end

    assign dac_en_o = en_q;
    assign dac_data0_o = data0_q;
    assign dac_data1_o = data1_q;
    assign dac_upd0_o = upd_q[0];
    assign dac_upd1_o = upd_q[1];
    assign dac_pd0_o = pd0_q;
    assign dac_pd1_o = pd1_q;
    assign busy_o = busy_q;
    assign frame_cnt_o = cnt_q;
endmodule

// File: tb/tb_dac_update_scheduler.sv
// tb_dac_update_scheduler: frame-phase reference model compared every cycle, plus directed scenarios.
module tb_dac_update_scheduler;
    localparam int F = 360;
    localparam int T = 1024;

    logic        clk = 1'b0;
    logic        rst_i, enable_i, sync_mode_i;
    logic [11:0] ch0_data_i, ch1_data_i;
    logic        ch0_valid_i, ch1_valid_i, ch0_ready_o, ch1_ready_o;
    logic [1:0]  pd0_i, pd1_i, dac_pd0_o, dac_pd1_o;
    logic        dac_en_o, dac_upd0_o, dac_upd1_o, busy_o;
    logic [11:0] dac_data0_o, dac_data1_o;
    logic [15:0] frame_cnt_o;

    int checks = 0;
    int errs = 0;

    dac_update_scheduler #(.FRAME_CYCLES(F), .SYNC_TIMEOUT(T)) dut (
        .clk(clk), .rst_i(rst_i), .enable_i(enable_i), .sync_mode_i(sync_mode_i),
        .ch0_data_i(ch0_data_i), .ch0_valid_i(ch0_valid_i), .ch0_ready_o(ch0_ready_o),
        .ch1_data_i(ch1_data_i), .ch1_valid_i(ch1_valid_i), .ch1_ready_o(ch1_ready_o),
        .pd0_i(pd0_i), .pd1_i(pd1_i), .dac_en_o(dac_en_o),
        .dac_data0_o(dac_data0_o), .dac_data1_o(dac_data1_o),
        .dac_upd0_o(dac_upd0_o), .dac_upd1_o(dac_upd1_o),
        .dac_pd0_o(dac_pd0_o), .dac_pd1_o(dac_pd1_o),
        .busy_o(busy_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errs++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference model: phase counts cycles since launch (0 idle, 1 load, 2 start, 3..F+2 wait)
    int          m_phase, m_to;
    logic [1:0]  m_pend, m_mask, m_acc;
    logic [11:0] m_hold0, m_hold1, m_d0, m_d1;
    logic [1:0]  m_pd0, m_pd1;
    logic [15:0] m_cnt;
    logic        m_one, m_go;

    assign m_one = m_pend[0] ^ m_pend[1];
    assign m_go = (m_phase == 0) && enable_i &&
                  (sync_mode_i ? ((m_pend == 2'b11) || (m_one && m_to == T - 1)) : (m_pend != 2'b00));
    assign m_acc = {ch1_valid_i, ch0_valid_i} & ~m_pend;

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            m_phase <= 0; m_to <= 0; m_pend <= 2'b00; m_mask <= 2'b00;
            m_hold0 <= '0; m_hold1 <= '0; m_d0 <= '0; m_d1 <= '0;
            m_pd0 <= '0; m_pd1 <= '0; m_cnt <= '0;
        end else begin
            m_phase <= (m_phase == 0) ? (m_go ? 1 : 0) : (m_phase == F + 2 ? 0 : m_phase + 1);
            if (m_go) begin
                m_mask <= m_pend;
                if (m_pend[0]) m_d0 <= m_hold0;
                if (m_pend[1]) m_d1 <= m_hold1;
                m_pd0 <= pd0_i;
                m_pd1 <= pd1_i;
            end
            if (m_phase == 1) m_cnt <= m_cnt + 16'd1;
            m_pend <= (m_pend & ~((m_phase == 1) ? m_mask : 2'b00)) | m_acc;
            if (m_acc[0]) m_hold0 <= ch0_data_i;
            if (m_acc[1]) m_hold1 <= ch1_data_i;
            m_to <= (m_phase == 0 && sync_mode_i && m_one) ? (m_to < T - 1 ? m_to + 1 : m_to) : 0;
        end
    end

    always @(negedge clk) begin
        chk("ready0", 32'(ch0_ready_o), 32'(!m_pend[0]));
        chk("ready1", 32'(ch1_ready_o), 32'(!m_pend[1]));
        chk("upd0", 32'(dac_upd0_o), 32'(m_phase == 1 && m_mask[0]));
        chk("upd1", 32'(dac_upd1_o), 32'(m_phase == 1 && m_mask[1]));
        chk("en", 32'(dac_en_o), 32'(m_phase == 2));
        chk("busy", 32'(busy_o), 32'(m_phase != 0));
        chk("data0", 32'(dac_data0_o), 32'(m_d0));
        chk("data1", 32'(dac_data1_o), 32'(m_d1));
        chk("pd0", 32'(dac_pd0_o), 32'(m_pd0));
        chk("pd1", 32'(dac_pd1_o), 32'(m_pd1));
        chk("frame_cnt", 32'(frame_cnt_o), 32'(m_cnt));
    end

    task automatic send(input int ch, input logic [11:0] v);
        int n = 0;
        while ((ch == 0 ? !ch0_ready_o : !ch1_ready_o) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) timeout("send_ready");
        if (ch == 0) begin ch0_data_i = v; ch0_valid_i = 1'b1; end
        else begin ch1_data_i = v; ch1_valid_i = 1'b1; end
        @(posedge clk);
        #1;
        if (ch == 0) ch0_valid_i = 1'b0;
        else ch1_valid_i = 1'b0;
    endtask

    task automatic wait_quiet(input int bound);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy_o || !ch0_ready_o || !ch1_ready_o) && n < bound);
        if (n >= bound) timeout("wait_quiet");
    endtask

    task automatic wait_upd(output int n, input int bound);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dac_upd0_o || dac_upd1_o) && n < bound);
        if (n >= bound) timeout("wait_upd");
    endtask

    task automatic wait_en(output int n, input int bound);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dac_en_o && n < bound);
        if (n >= bound) timeout("wait_en");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, last, np, seen;
        logic [15:0] cnt_before;
        rst_i = 1'b1; enable_i = 1'b0; sync_mode_i = 1'b0;
        ch0_data_i = '0; ch1_data_i = '0; ch0_valid_i = 1'b0; ch1_valid_i = 1'b0;
        pd0_i = 2'b00; pd1_i = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_ready0", 32'(ch0_ready_o), 32'd1);
        chk("rst_ready1", 32'(ch1_ready_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_cnt", 32'(frame_cnt_o), 32'd0);
        #2 rst_i = 1'b0;
        enable_i = 1'b1; pd0_i = 2'b01; pd1_i = 2'b10;
        @(negedge clk);

        // single ch0 sample, non-sync
        send(0, 12'hABC);
        @(negedge clk);
        chk("t1_no_upd_yet", 32'(dac_upd0_o), 32'd0);
        @(negedge clk);
        chk("t1_upd0", 32'(dac_upd0_o), 32'd1);
        chk("t1_upd1", 32'(dac_upd1_o), 32'd0);
        chk("t1_data0", 32'(dac_data0_o), 32'h0ABC);
        chk("t1_pd0", 32'(dac_pd0_o), 32'd1);
        @(negedge clk);
        chk("t1_en", 32'(dac_en_o), 32'd1);
        chk("t1_cnt", 32'(frame_cnt_o), 32'd1);
        wait_quiet(1000);

        // both producers streaming
        ch0_valid_i = 1'b1; ch1_valid_i = 1'b1; last = -1; np = 0;
        for (int i = 0; i < 4 * 363 + 10; i++) begin
            @(negedge clk);
            if (dac_en_o) begin
                if (last >= 0) chk("t2_period", 32'(i - last), 32'd363);
                last = i;
                np++;
            end
            if (dac_upd0_o) chk("t2_ready_low", 32'(ch0_ready_o), 32'd0);
            ch0_data_i = 12'(i);
            ch1_data_i = 12'(i * 7);
        end
        chk("t2_frames", 32'(np), 32'd5);
        ch0_valid_i = 1'b0; ch1_valid_i = 1'b0;
        wait_quiet(2000);

        // sync pairing
        sync_mode_i = 1'b1;
        cnt_before = frame_cnt_o;
        send(0, 12'h100);
        repeat (50) @(negedge clk);
        chk("t3_waiting", 32'(busy_o), 32'd0);
        send(1, 12'h200);
        wait_upd(n, 100);
        chk("t3_latency", 32'(n), 32'd2);
        chk("t3_upd0", 32'(dac_upd0_o), 32'd1);
        chk("t3_upd1", 32'(dac_upd1_o), 32'd1);
        chk("t3_data0", 32'(dac_data0_o), 32'h100);
        chk("t3_data1", 32'(dac_data1_o), 32'h200);
        wait_quiet(1000);
        chk("t3_one_frame", 32'(frame_cnt_o), 32'(cnt_before + 16'd1));

        // sync timeout with only ch1
        send(1, 12'h7FF);
        wait_upd(n, 2000);
        chk("t4_latency", 32'(n), 32'd1025);
        chk("t4_upd0", 32'(dac_upd0_o), 32'd0);
        chk("t4_upd1", 32'(dac_upd1_o), 32'd1);
        chk("t4_data1", 32'(dac_data1_o), 32'h7FF);
        chk("t4_data0_kept", 32'(dac_data0_o), 32'h100);
        wait_quiet(1000);
        sync_mode_i = 1'b0;

        // enable dropped during WAIT
        @(negedge clk);
        send(0, 12'h111);
        wait_en(n, 100);
        repeat (5) @(negedge clk);
        enable_i = 1'b0;
        send(0, 12'h222);
        n = 0;
        do begin @(negedge clk); n++; end while (busy_o && n < 1000);
        if (n >= 1000) timeout("t5_frame_end");
        repeat (20) begin
            @(negedge clk);
            chk("t5_no_launch", 32'(busy_o), 32'd0);
        end
        chk("t5_held", 32'(ch0_ready_o), 32'd0);
        chk("t5_data_old", 32'(dac_data0_o), 32'h111);
        enable_i = 1'b1;
        wait_en(n, 100);
        chk("t5_latency", 32'(n), 32'd2);
        chk("t5_data_new", 32'(dac_data0_o), 32'h222);
        wait_quiet(1000);

        // reset mid-WAIT with ch1 pending
        pd0_i = 2'b10; pd1_i = 2'b11;
        send(0, 12'h444);
        wait_en(n, 100);
        repeat (10) @(negedge clk);
        send(1, 12'h333);
        repeat (10) @(negedge clk);
        chk("t6_busy", 32'(busy_o), 32'd1);
        chk("t6_pending1", 32'(ch1_ready_o), 32'd0);
        chk("t6_pd0_set", 32'(dac_pd0_o), 32'd2);
        #2 rst_i = 1'b1;
        #1;
        chk("t6_en", 32'(dac_en_o), 32'd0);
        chk("t6_busy0", 32'(busy_o), 32'd0);
        chk("t6_cnt", 32'(frame_cnt_o), 32'd0);
        chk("t6_data0", 32'(dac_data0_o), 32'd0);
        chk("t6_data1", 32'(dac_data1_o), 32'd0);
        chk("t6_pd0", 32'(dac_pd0_o), 32'd0);
        chk("t6_pd1", 32'(dac_pd1_o), 32'd0);
        chk("t6_ready0", 32'(ch0_ready_o), 32'd1);
        chk("t6_ready1", 32'(ch1_ready_o), 32'd1);
        @(negedge clk);
        #2 rst_i = 1'b0;
        seen = 0;
        repeat (400) begin
            @(negedge clk);
            if (dac_upd0_o || dac_upd1_o || dac_en_o) seen = 1;
        end
        chk("t6_no_pulse", 32'(seen), 32'd0);
        chk("t6_cnt_after", 32'(frame_cnt_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/dac_update_scheduler.md
# dac_update_scheduler

Sequences update frames for the two-channel serial DAC block. It accepts 12-bit samples from two independent upstream producers (IIR filter outputs) over valid/ready and buffers one sample per channel. It launches DAC frames, optionally waiting to pair both channels, and spaces frames so that a new frame never starts while the serial engine is still shifting. It sits between the filter datapath and the SPI DAC driver.

## Interface
- `FRAME_CYCLES`, 360: clock cycles the DAC driver needs from its enable pulse until it is idle again; ≥ 1.
- `SYNC_TIMEOUT`, 1024: in sync mode, cycles one channel may wait for its partner before a frame launches anyway; ≥ 1.
- `clk` in 1: system clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `enable_i` in 1: permit new frame launches.
- `sync_mode_i` in 1: 1 = pair channels, 0 = launch on any pending sample.
- `ch0_data_i` in 12: channel 0 sample.
- `ch0_valid_i` in 1: channel 0 sample valid.
- `ch0_ready_o` out 1: channel 0 can accept a sample.
- `ch1_data_i`, `ch1_valid_i`, `ch1_ready_o`: same for channel 1.
- `pd0_i`, `pd1_i` in 2 each: per-channel DAC operating mode.
- `dac_en_o` out 1: one-cycle frame start pulse to the DAC driver.
- `dac_data0_o`, `dac_data1_o` out 12 each: registered sample to the driver.
- `dac_upd0_o`, `dac_upd1_o` out 1 each: one-cycle pulse; the driver captures the matching data.
- `dac_pd0_o`, `dac_pd1_o` out 2 each: registered operating mode.
- `busy_o` out 1: high in LOAD, START and WAIT.
- `frame_cnt_o` out 16: count of launched frames; wraps from 0xFFFF to 0.

## Operation
- Per channel there is a 1-deep holding register plus a `pending` flag.
  - `chX_ready_o = ~pendingX`.
  - A transfer occurs when `valid & ready` at the clock edge: data is stored and `pending` is set.
- Launch condition, evaluated in IDLE with `enable_i = 1`:
  - `sync_mode_i = 0`: `pending0 | pending1`.
  - `sync_mode_i = 1`: `pending0 & pending1`, or exactly one pending with the timeout counter at `SYNC_TIMEOUT-1`.
- Timeout counter:
  - Counts only in IDLE while exactly one channel is pending and `sync_mode_i = 1`.
  - Otherwise held at 0.
- FSM states:
  - IDLE → LOAD on the launch condition.
  - LOAD (1 cycle):
    - For each pending channel: copy the holding register to `dac_dataX_o`, pulse `dac_updX_o`, clear `pending`.
    - Copy `pd0_i`/`pd1_i` to `dac_pdX_o`.
    - Go to START.
  - START (1 cycle): `dac_en_o = 1`; `frame_cnt_o` increments; load the wait counter with `FRAME_CYCLES-1`; go to WAIT.
  - WAIT: decrement the wait counter; at 0 go to IDLE.
- A non-pending channel keeps its previous `dac_dataX_o` and gets no update pulse. The DAC repeats that channel's old value.
- `enable_i` low:
  - A frame already in LOAD, START or WAIT completes.
  - No new launch occurs.
  - Samples are still accepted and held.
- Reset values:
  - All outputs are 0 except `ch0_ready_o = ch1_ready_o = 1`.
  - `pending` flags are 0, FSM is in IDLE, all counters are 0.

## Timing
- Launch condition true in IDLE at cycle k:
  - LOAD at k+1, with `dac_updX_o` high.
  - START at k+2, with `dac_en_o` high.
  - WAIT from k+3 through k+2+`FRAME_CYCLES`.
  - IDLE at k+3+`FRAME_CYCLES`.
- Back-to-back frames: `dac_en_o` pulses are exactly `FRAME_CYCLES+3` cycles apart.
- Sample accepted at edge e: `pending` is visible at e+1. If the FSM is in IDLE at e+1, `dac_updX_o` pulses at e+2 in non-sync mode.
- Ready is low throughout LOAD, so no accept can coincide with the clear. Ready rises in START, so a new sample may be accepted during WAIT. That sample does not affect `dac_dataX_o` until the next LOAD.
- Launch evaluated with one channel pending and the partner's valid arriving in the same cycle (sync mode):
  - The partner's pending flag is not yet set, so the condition sees only one channel.
  - The launch waits unless the timeout counter is already at `SYNC_TIMEOUT-1`.
- `sync_mode_i` toggled mid-frame: takes effect at the next IDLE evaluation. The timeout counter clears while not in sync mode.
- Reset asserted mid-frame: everything clears immediately. `dac_en_o` drops, buffered samples are discarded, and no further pulses occur until relaunch.

## Structure
- Package `dac_sched_pkg` holds:
  - The FSM state enum (IDLE, LOAD, START, WAIT).
  - `DAC_DATA_W = 12` and `DAC_PD_W = 2`.
  - The PD encodings: `PD_NORMAL = 2'b00`, `PD_1K = 2'b01`, `PD_100K = 2'b10`, `PD_HIZ = 2'b11`.
- Sub-module `dac_sched_chan`, instantiated twice, contains:
  - The holding register, the `pending` flag and the valid/ready logic.
  - A `clear` input driven by LOAD.
- Wait counter width: `$clog2(FRAME_CYCLES)`. Timeout counter width: `$clog2(SYNC_TIMEOUT)`.

## Test plan
- Non-sync mode, single ch0 sample 0xABC at idle → `dac_upd0_o` asserts 2 cycles after the accept with `dac_data0_o = 0xABC`, `dac_upd1_o` stays 0, `dac_en_o` pulses 1 cycle later, `frame_cnt_o = 1`.
- Non-sync mode, both producers streaming continuously → `dac_en_o` period is exactly 363 cycles (default parameters) and ready deasserts between accepts.
- Sync mode, ch0 = 0x100 accepted, ch1 = 0x200 accepted 50 cycles later → a single frame with both update pulses in the same cycle.
- Sync mode, only ch1 = 0x7FF → the launch occurs after the timeout counter reaches 1023, with only `dac_upd1_o` asserted.
- `enable_i` dropped during WAIT, with a new ch0 sample accepted → no launch while disabled; the launch happens 2 cycles after `enable_i` returns high.
- `rst_i` pulsed mid-WAIT with ch1 pending → all outputs return to reset values, both ready = 1, no pulse for the discarded ch1 sample.
